uart_tx_buffered: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_buffered_sync_fifo.sv | 64 ++++++
 rtl/uart_tx_buffered.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the buffered UART transmitter.
//   tx_state_t      : serializer FSM state encoding
//   UART_DATA_BITS  : data bits per frame
//   FRAME_BITS_8N1  : bit-times per frame without parity
//   FRAME_BITS_8E1  : bit-times per frame with even parity
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int FRAME_BITS_8N1 = 10;   // start + 8 data + stop
    localparam int FRAME_BITS_8E1 = 11;   // start + 8 data + parity + stop

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } tx_state_t;

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with wrap-bit pointers. The head entry is presented
// combinationally on dout from the registered read pointer.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request/data (ignored while full)
//   pop        : read request (ignored while empty)
//   dout       : head entry
//   full/empty : status decoded from registered pointers
//   level      : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra bit so full and empty differ only in the MSB.
    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level     = r_wptr - r_rptr;
    assign dout      = r_mem[r_rptr[AW-1:0]];

    // Fullness is judged on the registered pointers, so a pop on the same
    // edge never makes room for a write that arrived while full.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage has no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// FIFO-buffered UART transmitter. Bus byte writes are queued in sync_fifo and
// a serializer drains them as 8N1 frames (8E1 when UART_TX_PARITY_EN is
// defined), back to back with no idle gap while data remains.
//   clk, reset        : clock, synchronous active-high reset
//   wr_valid, wr_data : byte write request; accepted when wr_ready is high
//   wr_ready          : FIFO not full
//   level             : FIFO occupancy 0..FIFO_DEPTH
//   busy              : FIFO non-empty or frame in progress
//   overflow, ovf_clr : sticky dropped-write flag and its clear (set wins)
//   uart_tx           : registered serial output, idles high
// Optional feature macro: UART_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_MHZ    = 12,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          uart_tx
);

    localparam int CLKS_PER_BIT = CLK_MHZ * 1000000 / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t   r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_overflow;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_bit_done;

    assign w_push     = wr_valid && !w_full;
    assign w_bit_done = (r_baud_cnt == BAUD_LAST);

    // Pop either from IDLE or on the last STOP cycle, the latter chaining the
    // next start bit directly onto the stop bit.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_tx     <= 1'b0;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            // Next bit is shift[1] since the shift lands this edge.
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b1;
                        r_state    <= ST_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_tx     <= 1'b0;
                            r_state  <= ST_START;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_tx       <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // A write refused because the FIFO was full sets the flag even if a
    // clear arrives on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (wr_valid && w_full) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign wr_ready = !w_full;
    assign busy     = (r_state != ST_IDLE) || !w_empty;
    assign overflow = r_overflow;
    assign uart_tx  = r_tx;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Directed bench for uart_tx_buffered at CLKS_PER_BIT=4 (4 MHz, 1 Mbaud) and
// FIFO_DEPTH=4. Outputs are sampled 1 time unit after each rising edge; the
// serial line is logged per cycle so whole frames are checked bit by bit.
// Honours UART_TX_PARITY_EN for frame length and the parity-byte steps.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = FRAME_BITS_8E1;
`else
    localparam int FB = FRAME_BITS_8N1;
`endif
    localparam int FC    = FB * CPB;
    localparam int LOG_N = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [2:0] level;
    logic       busy;
    logic       overflow;
    logic       ovf_clr;
    logic       uart_tx;

    uart_tx_buffered #(
        .CLK_MHZ    (4),
        .BAUD       (1000000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .level    (level),
        .busy     (busy),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    logic line_log [LOG_N];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < LOG_N) line_log[cyc] = uart_tx;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Line bits in transmit order: bit 0 is the start bit.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Each bit-time must hold its level for all CPB logged cycles.
    task automatic check_frame(input string tag, input int start, input logic [7:0] d);
        logic [10:0] exp;
        logic [3:0]  v;
        exp = frame_of(d);
        for (int k = 0; k < FB; k++) begin
            for (int j = 0; j < CPB; j++) v[j] = line_log[start + k*CPB + j];
            chk($sformatf("%s_bit%0d", tag, k), {28'd0, v}, {28'd0, {4{exp[k]}}});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        logic [7:0] t3b [4];
        t3b = '{8'h22, 8'h33, 8'h44, 8'h55};

        reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
        step(); step(); step();
        chk("rst_tx",       {31'd0, uart_tx},  32'd1);
        chk("rst_level",    {29'd0, level},    32'd0);
        reset = 1'b0;
        step();
        chk("idle_tx",      {31'd0, uart_tx},  32'd1);
        chk("idle_ready",   {31'd0, wr_ready}, 32'd1);
        chk("idle_level",   {29'd0, level},    32'd0);
        chk("idle_busy",    {31'd0, busy},     32'd0);
        chk("idle_ovf",     {31'd0, overflow}, 32'd0);

        // ---- single byte 8'h55 ----
        wr_data = 8'h55; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("t1_level_e0",  {29'd0, level},    32'd1);
        chk("t1_tx_e0",     {31'd0, uart_tx},  32'd1);
        chk("t1_busy_e0",   {31'd0, busy},     32'd1);
        step();
        s = cyc;
        chk("t1_tx_e1",     {31'd0, uart_tx},  32'd0);
        chk("t1_level_e1",  {29'd0, level},    32'd0);
        step_to(s + FC - 1);
        chk("t1_busy_last", {31'd0, busy},     32'd1);
        step();
        chk("t1_busy_end",  {31'd0, busy},     32'd0);
        chk("t1_tx_end",    {31'd0, uart_tx},  32'd1);
        check_frame("t1", s, 8'h55);

        // ---- burst 00, FF, A5 on consecutive cycles ----
        wr_valid = 1'b1; wr_data = 8'h00;
        step();
        chk("t2_level_w0",  {29'd0, level},    32'd1);
        wr_data = 8'hFF;
        step();
        s = cyc;
        // First byte is popped on this same edge, second byte pushed.
        chk("t2_level_w1",  {29'd0, level},    32'd1);
        chk("t2_tx_start",  {31'd0, uart_tx},  32'd0);
        wr_data = 8'hA5;
        step();
        wr_valid = 1'b0;
        chk("t2_level_w2",  {29'd0, level},    32'd2);
        step_to(s + FC);
        chk("t2_level_f2",  {29'd0, level},    32'd1);
        chk("t2_tx_f2",     {31'd0, uart_tx},  32'd0);
        step_to(s + 2*FC);
        chk("t2_level_f3",  {29'd0, level},    32'd0);
        step_to(s + 3*FC - 1);
        chk("t2_busy_last", {31'd0, busy},     32'd1);
        step();
        chk("t2_busy_end",  {31'd0, busy},     32'd0);
        check_frame("t2a", s,          8'h00);
        check_frame("t2b", s + FC,     8'hFF);
        check_frame("t2c", s + 2*FC,   8'hA5);

        // ---- overflow with depth 4 ----
        wr_valid = 1'b1; wr_data = 8'h11;
        step();
        wr_valid = 1'b0;
        step();
        s = cyc;
        chk("t3_level_pop", {29'd0, level},    32'd0);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = t3b[i];
            step();
            chk($sformatf("t3_level_w%0d", i), {29'd0, level}, 32'(i + 1));
            chk($sformatf("t3_ready_w%0d", i), {31'd0, wr_ready}, {31'd0, (i < 3)});
        end
        wr_data = 8'h66;
        step();
        wr_valid = 1'b0;
        chk("t3_ovf_set",   {31'd0, overflow}, 32'd1);
        chk("t3_level_ovf", {29'd0, level},    32'd4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr",   {31'd0, overflow}, 32'd0);
        wr_valid = 1'b1; ovf_clr = 1'b1;
        step();
        wr_valid = 1'b0; ovf_clr = 1'b0;
        chk("t3_set_wins",  {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        step_to(s + FC - 1);
        chk("t3_level_pre", {29'd0, level},    32'd4);
        chk("t3_ready_pre", {31'd0, wr_ready}, 32'd0);
        chk("t3_ovf_pre",   {31'd0, overflow}, 32'd0);
        // Write on the popping edge while full: dropped, pop still happens.
        wr_valid = 1'b1; wr_data = 8'h77;
        step();
        wr_valid = 1'b0;
        chk("t3_level_pop2", {29'd0, level},   32'd3);
        chk("t3_ovf_pop2",  {31'd0, overflow}, 32'd1);
        chk("t3_ready_pop2", {31'd0, wr_ready}, 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        step_to(s + 5*FC - 1);
        chk("t3_busy_last", {31'd0, busy},     32'd1);
        step();
        chk("t3_busy_end",  {31'd0, busy},     32'd0);
        check_frame("t3a", s,          8'h11);
        check_frame("t3b", s + FC,     8'h22);
        check_frame("t3c", s + 2*FC,   8'h33);
        check_frame("t3d", s + 3*FC,   8'h44);
        check_frame("t3e", s + 4*FC,   8'h55);

        // ---- reset mid-DATA of 8'h3C with another byte queued ----
        wr_valid = 1'b1; wr_data = 8'h3C;
        step();
        wr_data = 8'h99;
        step();
        s = cyc;
        wr_valid = 1'b0;
        chk("t4_level",     {29'd0, level},    32'd1);
        step_to(s + 2*CPB + 1);
        chk("t4_tx_pre",    {31'd0, uart_tx},  32'd0);
        reset = 1'b1;
        step();
        chk("t4_rst_tx",    {31'd0, uart_tx},  32'd1);
        chk("t4_rst_level", {29'd0, level},    32'd0);
        chk("t4_rst_busy",  {31'd0, busy},     32'd0);
        chk("t4_rst_ready", {31'd0, wr_ready}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 2*CPB; i++) step();
        chk("t4_post_busy", {31'd0, busy},     32'd0);
        chk("t4_post_tx",   {31'd0, uart_tx},  32'd1);
        wr_valid = 1'b1; wr_data = 8'h81;
        step();
        wr_valid = 1'b0;
        step();
        s = cyc;
        chk("t4_tx_start",  {31'd0, uart_tx},  32'd0);
        step_to(s + FC);
        chk("t4_busy_end",  {31'd0, busy},     32'd0);
        check_frame("t4", s, 8'h81);

`ifdef UART_TX_PARITY_EN
        // ---- even parity: 8'h07 -> 1, 8'h03 -> 0 ----
        wr_valid = 1'b1; wr_data = 8'h07;
        step();
        wr_valid = 1'b0;
        step();
        s = cyc;
        step_to(s + FC - 1);
        chk("t5_busy_last", {31'd0, busy},     32'd1);
        step();
        chk("t5_busy_end",  {31'd0, busy},     32'd0);
        chk("t5_par07",     {31'd0, line_log[s + 9*CPB + 1]}, 32'd1);
        check_frame("t5a", s, 8'h07);
        wr_valid = 1'b1; wr_data = 8'h03;
        step();
        wr_valid = 1'b0;
        step();
        s = cyc;
        step_to(s + FC);
        chk("t5_par03",     {31'd0, line_log[s + 9*CPB + 1]}, 32'd0);
        check_frame("t5b", s, 8'h03);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
